// File: rtl/gcd_sub_controller.sv
// Sequencing FSM for subtraction-based Euclid GCD. Owns the A/B operand registers,
// drives an external subtractor, and returns the result over a valid/ready channel.
module gcd_sub_controller #(
    parameter int W        = 32,
    parameter int MAX_ITER = 1024,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [W-1:0]     resp_gcd,
    output logic             resp_err,
    output logic [CNT_W-1:0] resp_cycles,
    output logic             busy,
    output logic [W-1:0]     sub_a,
    output logic [W-1:0]     sub_b,
    input  logic [W-1:0]     sub_diff
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [W-1:0]     a_reg, b_reg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [W-1:0]     a_step, b_step;
    logic             a_lt_b, b_zero, budget_hit;
    logic             accept, step, finish_ok, finish_err;

    // Ordering comes from a dedicated comparator; sub_diff only feeds the subtract path.
    assign a_lt_b     = a_reg < b_reg;
    assign b_zero     = (b_reg == '0);
    assign cnt_inc    = cnt + CNT_W'(1);
    assign budget_hit = (cnt_inc == CNT_W'(MAX_ITER));
    assign a_step     = a_lt_b ? b_reg : sub_diff;
    assign b_step     = a_lt_b ? a_reg : b_reg;

    assign sub_a = a_reg;
    assign sub_b = b_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        req_ready  = (state == IDLE) && !reset;
        resp_valid = (state == DONE);
        busy       = (state == CALC);
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (b_zero) begin
                    finish_ok  = 1'b1;
                    state_next = DONE;
                end else begin
                    step = 1'b1;
                    if (budget_hit) begin
                        finish_err = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg       <= '0;
            b_reg       <= '0;
            cnt         <= '0;
            resp_gcd    <= '0;
            resp_err    <= 1'b0;
            resp_cycles <= '0;
        end else begin
            if (accept) begin
                a_reg    <= req_a;
                b_reg    <= req_b;
                cnt      <= '0;
                resp_err <= 1'b0;
            end
            if (busy) begin
                cnt <= cnt_inc;
            end
            if (step) begin
                a_reg <= a_step;
                b_reg <= b_step;
            end
            if (finish_ok) begin
                resp_gcd    <= a_reg;
                resp_err    <= 1'b0;
                resp_cycles <= cnt_inc;
            end
            // Budget abort reports the A value this final step produced.
            if (finish_err) begin
                resp_gcd    <= a_step;
                resp_err    <= 1'b1;
                resp_cycles <= CNT_W'(MAX_ITER);
            end
        end
    end

endmodule

// File: tb/tb_gcd_sub_controller.sv
// Directed and random bench for gcd_sub_controller; three instances cover the
// default budget (1024) and the short budgets 16 and 3.
module tb_gcd_sub_controller;

    localparam int N   = 3;
    localparam int TMO = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [N];
    logic        req_ready [N];
    logic [31:0] req_a [N];
    logic [31:0] req_b [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_gcd [N];
    logic        resp_err [N];
    logic [31:0] resp_cycles [N];
    logic        busy [N];
    logic [31:0] sub_a [N];
    logic [31:0] sub_b [N];
    logic [31:0] sub_diff [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int MI = (g == 0) ? 1024 : ((g == 1) ? 16 : 3);
        gcd_sub_controller #(.W(32), .MAX_ITER(MI), .CNT_W(32)) dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_a(req_a[g]), .req_b(req_b[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_gcd(resp_gcd[g]), .resp_err(resp_err[g]), .resp_cycles(resp_cycles[g]),
            .busy(busy[g]), .sub_a(sub_a[g]), .sub_b(sub_b[g]), .sub_diff(sub_diff[g])
        );
        assign sub_diff[g] = sub_a[g] - sub_b[g];
    end

    function automatic logic [31:0] gcd_mod(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic step_model(input logic [31:0] a, input logic [31:0] b, input int mi,
                              output logic [31:0] g, output logic e, output int c);
        logic [31:0] t;
        c = 0;
        e = 1'b0;
        g = 0;
        while (1) begin
            c++;
            if (b == 0) begin
                g = a;
                break;
            end
            if (a < b) begin
                t = a; a = b; b = t;
            end else begin
                a = a - b;
            end
            if (c == mi) begin
                e = 1'b1;
                g = a;
                break;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the first CALC cycle.
    task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] b, output logic ok);
        req_a[d] = a;
        req_b[d] = b;
        req_valid[d] = 1'b1;
        for (int k = 0; k < 50 && req_ready[d] !== 1'b1; k++) @(negedge clk);
        ok = (req_ready[d] === 1'b1);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, output int n);
        n = 0;
        while (resp_valid[d] !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] b, output logic ok, output int n);
        do_req(d, a, b, ok);
        wait_resp(d, n);
    endtask

    task automatic ack(input int d);
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 || busy[d] !== 1'b0 || resp_err[d] !== 1'b0 ||
                resp_gcd[d] !== 32'd0 || resp_cycles[d] !== 32'd0 || sub_a[d] !== 32'd0 || sub_b[d] !== 32'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: rdy=%b vld=%b busy=%b err=%b gcd=%0d cyc=%0d a=%0d b=%0d required all 0",
                         d, req_ready[d], resp_valid[d], busy[d], resp_err[d], resp_gcd[d], resp_cycles[d], sub_a[d], sub_b[d]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL idle_ready dut%0d: req_ready=%b required 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] ta [6] = '{32'd12, 32'd4, 32'd8, 32'd4, 32'd0, 32'd4};
        logic [31:0] tb [6] = '{32'd8, 32'd8, 32'd4, 32'd4, 32'd4, 32'd0};
        logic ok;
        do_req(0, 32'd12, 32'd8, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept: accepted=%b required 1", ok);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (sub_a[0] !== ta[i] || sub_b[0] !== tb[i] || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL basic_trace[%0d]: a=%0d b=%0d busy=%b required a=%0d b=%0d busy=1",
                         i, sub_a[0], sub_b[0], busy[0], ta[i], tb[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_gcd[0] !== 32'd4 || resp_cycles[0] !== 32'd6 || resp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_resp: vld=%b gcd=%0d cyc=%0d err=%b required 1/4/6/0",
                     resp_valid[0], resp_gcd[0], resp_cycles[0], resp_err[0]);
        end
        ack(0);
        checks++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_ack: vld=%b rdy=%b required 0/1", resp_valid[0], req_ready[0]);
        end
    endtask

    task automatic test_zero();
        logic [31:0] va [3] = '{32'd7, 32'd0, 32'd0};
        logic [31:0] vb [3] = '{32'd0, 32'd5, 32'd0};
        logic [31:0] eg [3] = '{32'd7, 32'd5, 32'd0};
        int          ec [3] = '{1, 2, 1};
        logic ok;
        int n;
        for (int i = 0; i < 3; i++) begin
            txn(0, va[i], vb[i], ok, n);
            checks++;
            if (ok !== 1'b1 || resp_valid[0] !== 1'b1 || resp_gcd[0] !== eg[i] || resp_err[0] !== 1'b0 ||
                resp_cycles[0] !== 32'(ec[i]) || n != ec[i]) begin
                errors++;
                $display("FAIL zero[%0d]: ok=%b vld=%b gcd=%0d err=%b cyc=%0d lat=%0d required 1/1/%0d/0/%0d/%0d",
                         i, ok, resp_valid[0], resp_gcd[0], resp_err[0], resp_cycles[0], n, eg[i], ec[i], ec[i]);
            end
            ack(0);
        end
    endtask

    task automatic test_budget();
        logic ok;
        int n;
        txn(1, 32'd1000, 32'd1, ok, n);
        checks++;
        if (ok !== 1'b1 || resp_valid[1] !== 1'b1 || resp_err[1] !== 1'b1 || resp_gcd[1] !== 32'd984 ||
            resp_cycles[1] !== 32'd16 || n != 16) begin
            errors++;
            $display("FAIL budget_abort: ok=%b vld=%b err=%b gcd=%0d cyc=%0d lat=%0d required 1/1/1/984/16/16",
                     ok, resp_valid[1], resp_err[1], resp_gcd[1], resp_cycles[1], n);
        end
        ack(1);
        txn(2, 32'd1, 32'd1, ok, n);
        checks++;
        if (ok !== 1'b1 || resp_valid[2] !== 1'b1 || resp_err[2] !== 1'b0 || resp_gcd[2] !== 32'd1 ||
            resp_cycles[2] !== 32'd3 || n != 3) begin
            errors++;
            $display("FAIL budget_bzero_priority: ok=%b vld=%b err=%b gcd=%0d cyc=%0d lat=%0d required 1/1/0/1/3/3",
                     ok, resp_valid[2], resp_err[2], resp_gcd[2], resp_cycles[2], n);
        end
        ack(2);
    endtask

    task automatic test_back_to_back();
        logic ok;
        int n;
        txn(0, 32'd7, 32'd0, ok, n);
        for (int i = 0; i < 10; i++) begin
            req_a[0] = 32'd48;
            req_b[0] = 32'd18;
            req_valid[0] = (i % 2 == 1);
            @(negedge clk);
            checks++;
            if (resp_valid[0] !== 1'b1 || resp_gcd[0] !== 32'd7 || resp_cycles[0] !== 32'd1 ||
                resp_err[0] !== 1'b0 || req_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold_done[%0d]: vld=%b gcd=%0d cyc=%0d err=%b rdy=%b busy=%b required 1/7/1/0/0/0",
                         i, resp_valid[0], resp_gcd[0], resp_cycles[0], resp_err[0], req_ready[0], busy[0]);
            end
        end
        req_valid[0] = 1'b1;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        resp_ready[0] = 1'b0;
        checks++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || resp_gcd[0] !== 32'd7 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: vld=%b rdy=%b gcd=%0d busy=%b required 0/1/7/0",
                     resp_valid[0], req_ready[0], resp_gcd[0], busy[0]);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1 || sub_a[0] !== 32'd48 || sub_b[0] !== 32'd18) begin
            errors++;
            $display("FAIL pending_accept: busy=%b a=%0d b=%0d required 1/48/18", busy[0], sub_a[0], sub_b[0]);
        end
        wait_resp(0, n);
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_gcd[0] !== 32'd6 || resp_cycles[0] !== 32'd9 || resp_err[0] !== 1'b0 || n != 9) begin
            errors++;
            $display("FAIL pending_resp: vld=%b gcd=%0d cyc=%0d err=%b lat=%0d required 1/6/9/0/9",
                     resp_valid[0], resp_gcd[0], resp_cycles[0], resp_err[0], n);
        end
        ack(0);
    endtask

    task automatic test_reset_mid();
        logic ok;
        int n;
        do_req(0, 32'hFFFF_FFFF, 32'd1, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy=%b required 1", busy[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0 || resp_gcd[0] !== 32'd0 ||
            resp_cycles[0] !== 32'd0 || resp_err[0] !== 1'b0 || sub_a[0] !== 32'd0 || sub_b[0] !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b vld=%b rdy=%b gcd=%0d cyc=%0d err=%b a=%0d b=%0d required all 0",
                     busy[0], resp_valid[0], req_ready[0], resp_gcd[0], resp_cycles[0], resp_err[0], sub_a[0], sub_b[0]);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_resp: vld=%b rdy=%b required 0/1", resp_valid[0], req_ready[0]);
        end
        txn(0, 32'd9, 32'd6, ok, n);
        checks++;
        if (ok !== 1'b1 || resp_gcd[0] !== 32'd3 || resp_cycles[0] !== 32'd6 || resp_err[0] !== 1'b0 || n != 6) begin
            errors++;
            $display("FAIL mid_after: ok=%b gcd=%0d cyc=%0d err=%b lat=%0d required 1/3/6/0/6",
                     ok, resp_gcd[0], resp_cycles[0], resp_err[0], n);
        end
        ack(0);
    endtask

    task automatic test_random();
        logic [31:0] a, b, eg, mg;
        logic ee, ok, leak;
        int ec, n;
        for (int t = 0; t < 20; t++) begin
            a = 32'($urandom_range(0, 1023));
            b = 32'($urandom_range(0, 1023));
            step_model(a, b, 1024, mg, ee, ec);
            eg = ee ? mg : gcd_mod(a, b);
            do_req(0, a, b, ok);
            n = 0;
            leak = 1'b0;
            while (resp_valid[0] !== 1'b1 && n < TMO) begin
                if (req_ready[0] !== 1'b0) leak = 1'b1;
                req_valid[0] = 1'($urandom_range(0, 1));
                req_a[0] = $urandom;
                req_b[0] = $urandom;
                resp_ready[0] = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            req_valid[0] = 1'b0;
            resp_ready[0] = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b1) leak = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (ok !== 1'b1 || leak !== 1'b0 || resp_valid[0] !== 1'b1 || resp_gcd[0] !== eg ||
                resp_err[0] !== ee || resp_cycles[0] !== 32'(ec) || n != ec) begin
                errors++;
                $display("FAIL random[%0d] (%0d,%0d): ok=%b leak=%b vld=%b gcd=%0d err=%b cyc=%0d lat=%0d required 1/0/1/%0d/%b/%0d/%0d",
                         t, a, b, ok, leak, resp_valid[0], resp_gcd[0], resp_err[0], resp_cycles[0], n, eg, ee, ec, ec);
            end
            ack(0);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < N; d++) begin
            req_valid[d] = 1'b0;
            req_a[d] = 32'd0;
            req_b[d] = 32'd0;
            resp_ready[d] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero();
        test_budget();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
